inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which sets the number of encoded-word FIFO entries (a power of 2, at least 2).
REQ-002 SHALL have parameter AW, default 64, which sets the instruction-memory byte-address width.
REQ-003 SHALL have the following ports (clock and reset first; name, direction, width, meaning):
- clk, input, 1: the only clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins a program load.
- base_addr, input, AW: byte address of the first word; sampled on start.
- in_valid / in_ready, input / output, 1 each: instruction-field handshake.
- in_op, input, 4: operation selector, defined in REQ-007.
- in_rd, in_rn, in_rm, input, 5 each: destination (Rd/Rt), first source (Rn) and second source (Rm) register fields.
- in_imm, input, 26: immediate, shift amount or branch word-offset, taken from its LSBs.
- in_last, input, 1: the last instruction of the program.
- imem_we / imem_ready, output / input, 1 each: write handshake to instruction memory.
- imem_addr, output, AW: byte address of the current write.
- imem_wdata, output, 32: encoded machine word.
- busy, output, 1: high in state RUN.
- done, output, 1: high in state DONE.
- err_op, output, 1: sticky flag for an illegal op.
- word_cnt, output, 16: number of words written since start.

Function
REQ-004 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-005 SHALL make these transitions: IDLE to RUN on start; RUN to DONE on the imem write of the in_last word; DONE to RUN on start.
REQ-006 SHALL, on start in any state, load imem_addr from base_addr, clear word_cnt and err_op, and flush the FIFO.
REQ-007 SHALL encode each in_op as follows (bits listed MSB first):
- 0 ADDI: 1001000100, imm[11:0], Rn, Rd.
- 1 ADDS: 10101011000, Rm, 000000, Rn, Rd.
- 2 SUBS: 11101011000, Rm, 000000, Rn, Rd.
- 3 MUL: 10011011000, Rm, 011111, Rn, Rd.
- 4 LSL: 11010011011, 00000, imm[5:0], Rn, Rd.
- 5 LSR: 11010011010, 00000, imm[5:0], Rn, Rd.
- 6 B: 000101, imm[25:0].
- 7 CBZ: 10110100, imm[18:0], Rd.
- 8 B.LT: 01010100, imm[18:0], 01011.
- 9 LDUR: 11111000010, imm[8:0], 00, Rn, Rd.
- 10 STUR: 11111000000, imm[8:0], 00, Rn, Rd.
REQ-008 SHALL truncate immediates to the field width with no range checking.
REQ-009 SHALL assert in_ready only when the state is RUN and the FIFO is not full; there is no same-cycle pass-through when full.
REQ-010 SHALL accept a transfer when in_valid and in_ready are both high, encoding combinationally and pushing {word, last} into the FIFO at that edge.
REQ-011 SHALL not push an in_op value of 11 to 15: err_op sets and stays high until start or reset; if that op carries in_last, a NOP word 0xD503201F is pushed with last set instead.
REQ-012 SHALL drive imem_we high whenever the FIFO is non-empty, with imem_wdata equal to the FIFO head, held stable until imem_ready.
REQ-013 SHALL complete a write in the cycle imem_we and imem_ready are both high: pop the FIFO, add 4 to imem_addr (wrapping modulo 2^AW), and increment word_cnt (saturating at 0xFFFF).
REQ-014 SHALL give a minimum latency of one cycle: a word accepted at edge N appears on imem_we in cycle N+1.
REQ-015 SHALL allow a push and a pop in the same cycle, leaving the occupancy unchanged.
REQ-016 SHALL ignore in_valid in IDLE and DONE (in_ready is low).
REQ-017 SHALL give reset priority over start in the same cycle.
REQ-018 SHALL give start during RUN priority over a simultaneous push or pop; in-flight words are discarded.

Reset
REQ-019 SHALL, on reset, go to IDLE and clear the FIFO.
REQ-020 SHALL hold these values in reset: imem_we=0, imem_addr=0, imem_wdata=0, in_ready=0, busy=0, done=0, err_op=0, word_cnt=0.
REQ-021 SHALL, when reset is asserted mid-load, abort the load, lose the queued words, and not write to memory in the reset cycle.

Structure
REQ-022 SHALL place the op enum, opcode constants, the NOP constant and the B.LT cond constant in shared package inst_pkg.
REQ-023 SHALL implement the buffer as one sub-module, sync_fifo (parameters WIDTH, DEPTH; outputs full and empty).

Verification
REQ-024 SHALL check: start base 0x100; ADDI rd=1 rn=31 imm=5 with imem_ready tied 1 -> 0x910017E1 written at 0x100, one cycle after acceptance.
REQ-025 SHALL check: LDUR rd=2 rn=1 imm=8, then B imm=0x3FFFFFF (-1) with last -> 0xF8408022 at 0x100, then 0x17FFFFFF at 0x104; done=1, word_cnt=2.
REQ-026 SHALL check: imem_ready=0 with 5 pushes -> in_ready drops after 4; imem_wdata holds the first word; releasing imem_ready writes all words in order.
REQ-027 SHALL check: in_op=12 -> no write, err_op=1 until the next start.
REQ-028 SHALL check: reset pulse with 3 words queued -> imem_we=0 on the next cycle; FSM in IDLE; no further writes.
REQ-029 SHALL check: B.LT imm=2 and CBZ rd=3 imm=-2 -> 0x5400004B and 0xB4FFFFC3.

Source files
------------

// File: rtl/inst_pkg.sv
// Shared encodings for the instruction encoder: op selector, opcode fields,
// fixed constants and the combinational word encoder.
package inst_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_ADDS = 4'd1,
    OP_SUBS = 4'd2,
    OP_MUL  = 4'd3,
    OP_LSL  = 4'd4,
    OP_LSR  = 4'd5,
    OP_B    = 4'd6,
    OP_CBZ  = 4'd7,
    OP_BLT  = 4'd8,
    OP_LDUR = 4'd9,
    OP_STUR = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_BLT  = 8'b01010100;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [5:0]  MUL_RA   = 6'b011111;
  localparam logic [4:0]  COND_LT  = 5'b01011;
  localparam logic [31:0] NOP_WORD = 32'hD503201F;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'd10;
  endfunction

  // Immediates are simply truncated to each field's width.
  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                         input logic [4:0] rn, input logic [4:0] rm,
                                         input logic [25:0] imm);
    logic [31:0] w;
    w = NOP_WORD;
    case (op)
      OP_ADDI: w = {OPC_ADDI, imm[11:0], rn, rd};
      OP_ADDS: w = {OPC_ADDS, rm, 6'b000000, rn, rd};
      OP_SUBS: w = {OPC_SUBS, rm, 6'b000000, rn, rd};
      OP_MUL:  w = {OPC_MUL, rm, MUL_RA, rn, rd};
      OP_LSL:  w = {OPC_LSL, 5'b00000, imm[5:0], rn, rd};
      OP_LSR:  w = {OPC_LSR, 5'b00000, imm[5:0], rn, rd};
      OP_B:    w = {OPC_B, imm[25:0]};
      OP_CBZ:  w = {OPC_CBZ, imm[18:0], rd};
      OP_BLT:  w = {OPC_BLT, imm[18:0], COND_LT};
      OP_LDUR: w = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
      OP_STUR: w = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Instruction-field input handshake and instruction-memory write port.
interface inst_encoder_if #(parameter int AW = 64);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rd;
  logic [4:0]    in_rn;
  logic [4:0]    in_rm;
  logic [25:0]   in_imm;
  logic          in_last;
  logic          imem_we;
  logic          imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder_fifo.sv
// Synchronous FIFO with extra-MSB pointers; flush clears occupancy only.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign rdata = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (PW+1)'(1);
      if (pop && !empty) rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= wdata;
  end
endmodule

// File: rtl/inst_encoder.sv
// Encodes instruction fields into 32-bit machine words, buffers them and
// writes them to instruction memory at consecutive word addresses.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  inst_encoder_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic          err_op,
  output logic [15:0]   word_cnt
);
  state_e        state;
  state_e        state_nxt;
  logic          full;
  logic          empty;
  logic          acc;
  logic          legal;
  logic          push;
  logic          pop;
  logic [31:0]   enc_word;
  logic [31:0]   head_word;
  logic          head_last;
  logic [AW-1:0] addr;

  assign legal         = op_legal(bus.in_op);
  assign enc_word      = legal ? encode(bus.in_op, bus.in_rd, bus.in_rn, bus.in_rm, bus.in_imm)
                               : NOP_WORD;
  assign bus.in_ready  = (state == ST_RUN) && !full;
  assign acc           = bus.in_valid && bus.in_ready;
  // An illegal op is dropped unless it ends the program, where a NOP keeps the end marker.
  assign push          = acc && (legal || bus.in_last);
  assign bus.imem_we   = !empty && !reset;
  assign bus.imem_wdata = bus.imem_we ? head_word : 32'd0;
  assign bus.imem_addr = addr;
  assign pop           = bus.imem_we && bus.imem_ready;
  assign busy          = (state == ST_RUN);
  assign done          = (state == ST_DONE);

  sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .flush (reset || start),
    .push  (push),
    .wdata ({enc_word, bus.in_last}),
    .pop   (pop),
    .rdata ({head_word, head_last}),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)                                      state_nxt = ST_RUN;
    else if (state == ST_RUN && pop && head_last)   state_nxt = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      word_cnt <= '0;
      err_op   <= 1'b0;
    end else if (start) begin
      addr     <= base_addr;
      word_cnt <= '0;
      err_op   <= 1'b0;
    end else begin
      if (pop) begin
        addr <= addr + AW'(4);
        if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
      end
      if (acc && !legal) err_op <= 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder with hand-computed machine words.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base_addr = '0;
  logic        busy, done, err_op;
  logic [15:0] word_cnt;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];

  inst_encoder_if #(.AW(64)) bus ();

  inst_encoder #(.DEPTH(4), .AW(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err_op    (err_op),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  // A write is observed mid-cycle; it completes at the following rising edge.
  always @(negedge clk) begin
    if (bus.imem_we && bus.imem_ready) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [63:0] b);
    wr_addr.delete();
    wr_data.delete();
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input string tag, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm, input logic [25:0] imm,
                      input logic last);
    int guard;
    bus.in_op = op; bus.in_rd = rd; bus.in_rn = rn; bus.in_rm = rm;
    bus.in_imm = imm; bus.in_last = last; bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!bus.in_ready) check_val({tag, "_ready_timeout"}, 64'd0, 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (!done && guard < 50) begin
      tick();
      guard++;
    end
    if (!done) check_val({tag, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [63:0] a, input logic [31:0] d);
    check_val({tag, "_addr"}, (idx < wr_addr.size()) ? wr_addr[idx] : 64'hDEAD, a);
    check_val({tag, "_data"}, (idx < wr_data.size()) ? {32'd0, wr_data[idx]} : 64'hDEAD, {32'd0, d});
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rn = '0; bus.in_rm = '0;
    bus.in_imm = '0; bus.in_last = 1'b0; bus.imem_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_we", bus.imem_we, 0);
    check_val("rst_addr", bus.imem_addr, 0);
    check_val("rst_wdata", bus.imem_wdata, 0);
    check_val("rst_in_ready", bus.in_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err_op, 0);
    check_val("rst_cnt", word_cnt, 0);
    reset = 1'b0;
    tick();
    // Fields are ignored while idle.
    bus.in_valid = 1'b1;
    tick();
    check_val("idle_in_ready", bus.in_ready, 0);
    check_val("idle_we", bus.imem_we, 0);
    bus.in_valid = 1'b0;

    // ADDI single word, one-cycle latency
    pulse_start(64'h100);
    check_val("t1_busy", busy, 1);
    check_val("t1_addr0", bus.imem_addr, 64'h100);
    send("t1", 4'd0, 5'd1, 5'd31, 5'd0, 26'd5, 1'b0);
    check_val("t1_we", bus.imem_we, 1);
    check_val("t1_wdata", bus.imem_wdata, 64'h910017E1);
    check_val("t1_waddr", bus.imem_addr, 64'h100);
    check_val("t1_cnt_pre", word_cnt, 0);
    tick();
    check_val("t1_cnt", word_cnt, 1);
    check_val("t1_addr1", bus.imem_addr, 64'h104);
    check_val("t1_we_off", bus.imem_we, 0);

    // LDUR then B -1 with last; restart from RUN
    pulse_start(64'h100);
    check_val("t2_cnt_clr", word_cnt, 0);
    send("t2a", 4'd9, 5'd2, 5'd1, 5'd0, 26'd8, 1'b0);
    send("t2b", 4'd6, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b1);
    wait_done("t2");
    check_val("t2_nwr", wr_data.size(), 2);
    check_wr("t2_w0", 0, 64'h100, 32'hF8408022);
    check_wr("t2_w1", 1, 64'h104, 32'h17FFFFFF);
    check_val("t2_done", done, 1);
    check_val("t2_busy", busy, 0);
    check_val("t2_cnt", word_cnt, 2);
    check_val("t2_in_ready", bus.in_ready, 0);

    // Back-pressure: FIFO fills after 4 words
    bus.imem_ready = 1'b0;
    pulse_start(64'h200);
    send("t3a", 4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    send("t3b", 4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    send("t3c", 4'd3, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0);
    send("t3d", 4'd4, 5'd1, 5'd2, 5'd0, 26'd3, 1'b0);
    check_val("t3_full_in_ready", bus.in_ready, 0);
    bus.in_op = 4'd5; bus.in_rd = 5'd1; bus.in_rn = 5'd2; bus.in_imm = 26'h43;
    bus.in_last = 1'b1; bus.in_valid = 1'b1;
    tick();
    check_val("t3_hold_we", bus.imem_we, 1);
    check_val("t3_hold_wdata0", bus.imem_wdata, 64'hAB030041);
    tick();
    check_val("t3_hold_in_ready", bus.in_ready, 0);
    check_val("t3_hold_wdata1", bus.imem_wdata, 64'hAB030041);
    check_val("t3_hold_addr", bus.imem_addr, 64'h200);
    bus.imem_ready = 1'b1;
    send("t3e", 4'd5, 5'd1, 5'd2, 5'd0, 26'h43, 1'b1);
    wait_done("t3");
    check_val("t3_nwr", wr_data.size(), 5);
    check_wr("t3_w0", 0, 64'h200, 32'hAB030041);
    check_wr("t3_w1", 1, 64'h204, 32'hEB030041);
    check_wr("t3_w2", 2, 64'h208, 32'h9B067CA4);
    check_wr("t3_w3", 3, 64'h20C, 32'hD3600C41);
    check_wr("t3_w4", 4, 64'h210, 32'hD3400C41);
    check_val("t3_cnt", word_cnt, 5);

    // Illegal ops: dropped, sticky error, NOP when carrying last
    pulse_start(64'h300);
    send("t4a", 4'd12, 5'd1, 5'd1, 5'd1, 26'd1, 1'b0);
    repeat (3) tick();
    check_val("t4_nwr0", wr_data.size(), 0);
    check_val("t4_we", bus.imem_we, 0);
    check_val("t4_err", err_op, 1);
    send("t4b", 4'd13, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1);
    wait_done("t4");
    check_val("t4_nwr1", wr_data.size(), 1);
    check_wr("t4_nop", 0, 64'h300, 32'hD503201F);
    check_val("t4_err_held", err_op, 1);
    pulse_start(64'h500);
    check_val("t4_err_clr", err_op, 0);

    // Reset mid-load with 3 words queued
    bus.imem_ready = 1'b0;
    send("t5a", 4'd0, 5'd1, 5'd1, 5'd0, 26'd1, 1'b0);
    send("t5b", 4'd0, 5'd2, 5'd2, 5'd0, 26'd2, 1'b0);
    send("t5c", 4'd0, 5'd3, 5'd3, 5'd0, 26'd3, 1'b0);
    check_val("t5_we_queued", bus.imem_we, 1);
    reset = 1'b1;
    #1;
    check_val("t5_we_in_rst", bus.imem_we, 0);
    tick();
    reset = 1'b0;
    #1;
    check_val("t5_we_after", bus.imem_we, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_done", done, 0);
    check_val("t5_in_ready", bus.in_ready, 0);
    check_val("t5_cnt", word_cnt, 0);
    bus.imem_ready = 1'b1;
    repeat (5) tick();
    check_val("t5_nwr", wr_data.size(), 0);

    // Branch encodings with negative offset
    pulse_start(64'h400);
    send("t6a", 4'd8, 5'd0, 5'd0, 5'd0, 26'd2, 1'b0);
    send("t6b", 4'd7, 5'd3, 5'd0, 5'd0, 26'h3FFFFFE, 1'b1);
    wait_done("t6");
    check_wr("t6_blt", 0, 64'h400, 32'h5400004B);
    check_wr("t6_cbz", 1, 64'h404, 32'hB4FFFFC3);

    // Address wrap and immediate truncation
    pulse_start(64'hFFFF_FFFF_FFFF_FFFC);
    send("t7a", 4'd10, 5'd5, 5'd6, 5'd0, 26'h3FFFFFF, 1'b0);
    send("t7b", 4'd0, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b1);
    wait_done("t7");
    check_wr("t7_stur", 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hF81FF0C5);
    check_wr("t7_addi", 1, 64'h0, 32'h913FFC00);
    check_val("t7_addr", bus.imem_addr, 64'h4);
    check_val("t7_cnt", word_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
